// File: rtl/leap_mem_port_arbiter.sv
// Round-robin arbiter sharing leap_mem RAM port a between NUM_REQ load/store requesters.
// Issues one access per cycle, returns read data with a per-requester rvalid, and freezes on waitrequest.
module leap_mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memory_controller_waitrequest,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*32-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      conflict,
  output logic                      mem_en_a,
  output logic                      mem_we_a,
  output logic [ADDR_W-1:0]         mem_addr_a,
  output logic [DATA_W-1:0]         mem_in_a,
  output logic                      mem_byteena_a,
  input  logic [DATA_W-1:0]         mem_out_a
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  genvar gi;

  logic [ADDR_W-1:0] word_addr [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic              unused_addr_bits;

  // Byte addresses become word addresses; byte-lane and high bits are dropped on purpose.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign word_addr[gi] = req_addr[32*gi+2 +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
  end
  assign unused_addr_bits = ^req_addr;

  logic [IDX_W-1:0] ptr_reg;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand_idx;
  logic             grant_valid;
  logic             load_push;
  logic             final_in_valid;

  // Scan from the priority pointer upward, wrapping; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      cand_idx = cand_sum[IDX_W-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign grant_valid = win_found && !memory_controller_waitrequest && reset;
  assign load_push   = grant_valid && !req_we[win_idx];

  always_comb begin
    gnt        = '0;
    mem_en_a   = 1'b0;
    mem_we_a   = 1'b0;
    mem_addr_a = '0;
    mem_in_a   = '0;
    if (grant_valid) begin
      gnt[win_idx] = 1'b1;
      mem_en_a     = 1'b1;
      mem_we_a     = req_we[win_idx];
      mem_addr_a   = word_addr[win_idx];
      if (req_we[win_idx]) mem_in_a = wdata_arr[win_idx];
    end
  end

  assign mem_byteena_a = 1'b1;
  assign conflict      = ($countones(req) > 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (grant_valid) begin
      ptr_reg <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  logic             tag_valid_reg [RD_LAT];
  logic [IDX_W-1:0] tag_idx_reg   [RD_LAT];
  logic [DATA_W-1:0] rdata_reg;

  // RAM output is captured on the same edge that moves a load tag into the output stage.
  if (RD_LAT == 1) begin : g_lat1
    assign final_in_valid = load_push;
  end else begin : g_latn
    assign final_in_valid = tag_valid_reg[RD_LAT-2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_idx_reg[s]   <= '0;
      end
      rdata_reg <= '0;
    end else if (!memory_controller_waitrequest) begin
      tag_valid_reg[0] <= load_push;
      tag_idx_reg[0]   <= win_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_idx_reg[s]   <= tag_idx_reg[s-1];
      end
      if (final_in_valid) rdata_reg <= mem_out_a;
    end
  end

  // A stalled output tag stays put and is only presented once the stall clears.
  always_comb begin
    rvalid = '0;
    if (tag_valid_reg[RD_LAT-1] && !memory_controller_waitrequest)
      rvalid[tag_idx_reg[RD_LAT-1]] = 1'b1;
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_leap_mem_port_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT 1 and 2) share stimulus and are compared
// every cycle against a queue-based reference model of the arbitration and read-return rules.
module tb_leap_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic              wr;
  logic [N-1:0]      req;
  logic [N-1:0]      req_we;
  logic [N*32-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     mem_out_a;

  logic [N-1:0]  gnt_l1, rvalid_l1, gnt_l2, rvalid_l2;
  logic [DW-1:0] rdata_l1, rdata_l2, mem_in_l1, mem_in_l2;
  logic [AW-1:0] mem_addr_l1, mem_addr_l2;
  logic          conflict_l1, conflict_l2, mem_en_l1, mem_en_l2;
  logic          mem_we_l1, mem_we_l2, byteena_l1, byteena_l2;

  leap_mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .memory_controller_waitrequest(wr),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt_l1), .rvalid(rvalid_l1), .rdata(rdata_l1), .conflict(conflict_l1),
    .mem_en_a(mem_en_l1), .mem_we_a(mem_we_l1), .mem_addr_a(mem_addr_l1),
    .mem_in_a(mem_in_l1), .mem_byteena_a(byteena_l1), .mem_out_a(mem_out_a)
  );

  leap_mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_l2 (
    .clk(clk), .reset(reset), .memory_controller_waitrequest(wr),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt_l2), .rvalid(rvalid_l2), .rdata(rdata_l2), .conflict(conflict_l2),
    .mem_en_a(mem_en_l2), .mem_we_a(mem_we_l2), .mem_addr_a(mem_addr_l2),
    .mem_in_a(mem_in_l2), .mem_byteena_a(byteena_l2), .mem_out_a(mem_out_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          idx;
    int          cnt;
    logic [31:0] data;
  } pend_t;

  int          n_vec;
  int          n_miscmp;
  bit          r_act [N];
  bit          r_we [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_wdata [N];
  int          ptr_m;
  pend_t       pend_q [$];
  bit          in_reset;
  bit          fixed_mem;
  logic [31:0] fixed_val;
  int          last_win;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_winner();
    int j;
    if (in_reset || wr) return -1;
    for (int k = 0; k < N; k++) begin
      j = (ptr_m + k) % N;
      if (r_act[j]) return j;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    r_act[i]   = 1'b1;
    r_we[i]    = bit'($urandom_range(1));
    r_addr[i]  = $urandom();
    r_wdata[i] = $urandom();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]               = r_act[i];
      req_we[i]            = r_we[i];
      req_addr[32*i +: 32] = r_addr[i];
      req_wdata[32*i +: 32] = r_wdata[i];
    end
    mem_out_a = fixed_mem ? fixed_val : $urandom();
  endtask

  task automatic check_outputs();
    int            w;
    int            nact;
    logic [N-1:0]  eg, erv1, erv2;
    logic [31:0]   erd1, erd2, eaddr, ein;
    bit            ewe;
    w = model_winner();
    eg = '0; ewe = 1'b0; eaddr = '0; ein = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ewe   = r_we[w];
      eaddr = (r_addr[w] >> 2) & 32'h3FF;
      if (r_we[w]) ein = r_wdata[w];
    end
    check_val("gnt_l1", gnt_l1, eg);
    check_val("gnt_l2", gnt_l2, eg);
    check_val("mem_en_l1", mem_en_l1, w >= 0);
    check_val("mem_en_l2", mem_en_l2, w >= 0);
    check_val("mem_we_l1", mem_we_l1, ewe);
    check_val("mem_we_l2", mem_we_l2, ewe);
    check_val("mem_addr_l1", mem_addr_l1, eaddr);
    check_val("mem_addr_l2", mem_addr_l2, eaddr);
    check_val("mem_in_l1", mem_in_l1, ein);
    check_val("mem_in_l2", mem_in_l2, ein);
    check_val("byteena_l1", byteena_l1, 1);
    check_val("byteena_l2", byteena_l2, 1);
    erv1 = '0; erv2 = '0; erd1 = '0; erd2 = '0;
    if (!wr && !in_reset) begin
      foreach (pend_q[i]) begin
        if (pend_q[i].cnt == pend_q[i].lat) begin
          if (pend_q[i].lat == 1) begin
            erv1[pend_q[i].idx] = 1'b1;
            erd1 = pend_q[i].data;
          end else begin
            erv2[pend_q[i].idx] = 1'b1;
            erd2 = pend_q[i].data;
          end
        end
      end
    end
    check_val("rvalid_l1", rvalid_l1, erv1);
    check_val("rvalid_l2", rvalid_l2, erv2);
    if (erv1 != '0) check_val("rdata_l1", rdata_l1, erd1);
    if (erv2 != '0) check_val("rdata_l2", rdata_l2, erd2);
    if (in_reset) begin
      check_val("rst_rdata_l1", rdata_l1, 0);
      check_val("rst_rdata_l2", rdata_l2, 0);
    end else begin
      nact = 0;
      for (int i = 0; i < N; i++) nact += int'(r_act[i]);
      check_val("conflict_l1", conflict_l1, nact > 1);
      check_val("conflict_l2", conflict_l2, nact > 1);
    end
  endtask

  // Each queued load counts the unstalled edges since its grant; it is presented when the count hits its latency.
  task automatic model_edge();
    pend_t nq [$];
    pend_t e;
    int    w;
    last_win = -1;
    if (in_reset || wr) return;
    w = model_winner();
    last_win = w;
    foreach (pend_q[i]) begin
      e = pend_q[i];
      if (e.cnt != e.lat) begin
        e.cnt++;
        if (e.cnt == e.lat) e.data = mem_out_a;
        nq.push_back(e);
      end
    end
    if (w >= 0) begin
      ptr_m = (w + 1) % N;
      if (!r_we[w]) begin
        nq.push_back('{1, w, 1, mem_out_a});
        nq.push_back('{2, w, 1, 32'h0});
      end
    end
    pend_q = nq;
  endtask

  task automatic run_cycle();
    drive();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    #1;
    reset    = 1'b0;
    in_reset = 1'b1;
    pend_q.delete();
    ptr_m    = 0;
    #1;
    check_outputs();
    run_cycle();
    run_cycle();
    reset    = 1'b0;
    reset    = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) r_act[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [31:0] addr, input logic [31:0] data);
    r_act[i] = 1'b1; r_we[i] = we; r_addr[i] = addr; r_wdata[i] = data;
  endtask

  initial begin
    n_vec = 0; n_miscmp = 0; ptr_m = 0; last_win = -1;
    fixed_mem = 1'b0; fixed_val = '0; wr = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_act[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    reset = 1'b0; in_reset = 1'b1;
    run_cycle();
    run_cycle();
    reset = 1'b1; in_reset = 1'b0;

    // Single load, constant RAM output
    fixed_mem = 1'b1; fixed_val = 32'hAB;
    set_req(0, 1'b0, 32'h10, 32'h0);
    drive(); #1;
    check_val("t1_addr", mem_addr_l1, 4);
    check_val("t1_gnt", gnt_l1, 3'b001);
    run_cycle();
    check_val("t1_rvalid", rvalid_l1, 3'b001);
    check_val("t1_rdata", rdata_l1, 32'hAB);
    idle_all();
    run_cycle();
    fixed_mem = 1'b0;

    // All three requesting continuously
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 + 32'(4*i), 32'h0);
    repeat (6) run_cycle();
    idle_all();
    run_cycle();

    // Store produces no read return
    set_req(1, 1'b1, 32'h8, 32'h55);
    drive(); #1;
    check_val("t3_we", mem_we_l1, 1);
    check_val("t3_addr", mem_addr_l1, 2);
    check_val("t3_din", mem_in_l1, 32'h55);
    run_cycle();
    idle_all();
    run_cycle();
    run_cycle();

    // Load followed by a three-cycle stall
    set_req(2, 1'b0, 32'h40, 32'h0);
    run_cycle();
    idle_all();
    wr = 1'b1;
    repeat (3) run_cycle();
    wr = 1'b0;
    run_cycle();
    run_cycle();

    // Back-to-back loads for the two-cycle latency instance
    set_req(0, 1'b0, 32'h20, 32'h0);
    run_cycle();
    idle_all();
    set_req(2, 1'b0, 32'h24, 32'h0);
    run_cycle();
    check_val("t5_rv0_l2", rvalid_l2, 3'b001);
    idle_all();
    run_cycle();
    check_val("t5_rv2_l2", rvalid_l2, 3'b100);
    run_cycle();
    run_cycle();

    // Reset one cycle after a load grant
    set_req(1, 1'b0, 32'h30, 32'h0);
    run_cycle();
    idle_all();
    reset_pulse();
    run_cycle();
    run_cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h200 + 32'(4*i), 32'h0);
    run_cycle();
    idle_all();
    run_cycle();
    run_cycle();

    // Randomized traffic with stalls and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) reset_pulse();
      wr = ($urandom_range(4) == 0);
      run_cycle();
      if (last_win >= 0) begin
        if ($urandom_range(1) == 1) new_req(last_win);
        else r_act[last_win] = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (!r_act[i] && i != last_win && $urandom_range(9) < 4) new_req(i);
    end
    wr = 1'b0;
    idle_all();
    run_cycle();
    run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
